// File: rtl/dff_bank_arbiter.sv
// Four-requester round-robin arbiter guarding a shared WIDTH-bit register.
// Optional WAIT time limit enabled by defining ARB_TIMEOUT_EN.
module dff_bank_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               r,
  input  logic [3:0]         req,
  input  logic [4*WIDTH-1:0] wdata,
  output logic [3:0]         gnt,
  output logic [WIDTH-1:0]   q,
  output logic               done,
  output logic               busy,
  output logic               timeout
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t           state_q;
  logic [1:0]       ptr_q;
  logic [1:0]       g_q;
  logic [3:0]       gnt_q;
  logic [WIDTH-1:0] data_q;
  logic             done_q;
  logic             busy_q;
  logic [1:0]       win_d;
  logic [WIDTH-1:0] wslice_d;

`ifdef ARB_TIMEOUT_EN
  logic [2:0]       cnt_q;
  logic             timeout_q;
`endif

  // First set request bit searching upward from ptr_v, wrapping modulo 4.
  function automatic logic [1:0] rr_pick(input logic [3:0] req_v, input logic [1:0] ptr_v);
    logic [1:0] pick;
    logic [1:0] idx;
    logic       found;
    pick  = ptr_v;
    found = 1'b0;
    for (int k = 0; k < 4; k++) begin
      idx = ptr_v + 2'(k);
      if (!found && req_v[idx]) begin
        pick  = idx;
        found = 1'b1;
      end else begin
        pick  = pick;
      end
    end
    return pick;
  endfunction

  // Round-robin winner and the current owner's write slice.
  always_comb begin
    win_d    = rr_pick(req, ptr_q);
    wslice_d = '0;
    case (g_q)
      2'd0:    wslice_d = wdata[0*WIDTH +: WIDTH];
      2'd1:    wslice_d = wdata[1*WIDTH +: WIDTH];
      2'd2:    wslice_d = wdata[2*WIDTH +: WIDTH];
      2'd3:    wslice_d = wdata[3*WIDTH +: WIDTH];
      default: wslice_d = '0;
    endcase
  end

  // Arbiter FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (!r) begin
      state_q   <= IDLE;
      ptr_q     <= 2'd0;
      g_q       <= 2'd0;
      gnt_q     <= 4'b0000;
      data_q    <= '0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      cnt_q     <= 3'd0;
      timeout_q <= 1'b0;
`endif
    end else begin
      done_q    <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      timeout_q <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (|req) begin
            state_q <= GRANT;
            busy_q  <= 1'b1;
            g_q     <= win_d;
            gnt_q   <= 4'b0001 << win_d;
            ptr_q   <= win_d + 2'd1;
          end
        end
        GRANT: begin
          // A requester that withdraws before its write edge aborts without touching q.
          if (req[g_q]) begin
            data_q  <= wslice_d;
            done_q  <= 1'b1;
            state_q <= WAIT;
`ifdef ARB_TIMEOUT_EN
            cnt_q   <= 3'd0;
`endif
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            gnt_q   <= 4'b0000;
          end
        end
        WAIT: begin
          if (!req[g_q]) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            gnt_q   <= 4'b0000;
          end else begin
`ifdef ARB_TIMEOUT_EN
            // Normal release wins if req drops on the same edge the limit is hit.
            if (cnt_q == 3'd7) begin
              state_q   <= IDLE;
              busy_q    <= 1'b0;
              gnt_q     <= 4'b0000;
              timeout_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 3'd1;
            end
`endif
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          gnt_q   <= 4'b0000;
        end
      endcase
    end
  end

  assign gnt  = gnt_q;
  assign q    = data_q;
  assign done = done_q;
  assign busy = busy_q;
`ifdef ARB_TIMEOUT_EN
  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_dff_bank_arbiter.sv
// Self-checking bench for dff_bank_arbiter: directed scenarios, then random traffic
// compared against a transaction-level reference model.
module tb_dff_bank_arbiter;
  localparam int W = 8;

  logic           clk;
  logic           r_i;
  logic [3:0]     req_i;
  logic [4*W-1:0] wdata_i;
  logic [3:0]     gnt;
  logic [W-1:0]   q;
  logic           done;
  logic           busy;
  logic           timeout;

  int checks;
  int failures;

  // reference model: phase 0 idle, 1 granted awaiting write, 2 holding after write
  int       m_phase;
  int       m_owner;
  int       m_ptr;
  int       m_wait;
  logic [W-1:0] m_q;
  logic     m_done;
  logic     m_to;

  dff_bank_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .r(r_i), .req(req_i), .wdata(wdata_i),
    .gnt(gnt), .q(q), .done(done), .busy(busy), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    int g;
    if (!r_i) begin
      m_phase = 0; m_owner = 0; m_ptr = 0; m_wait = 0;
      m_q = '0; m_done = 1'b0; m_to = 1'b0;
    end else begin
      m_done = 1'b0;
      m_to   = 1'b0;
      if (m_phase == 0) begin
        if (req_i != 4'b0000) begin
          g = -1;
          for (int k = 0; k < 4; k++)
            if (g < 0 && req_i[(m_ptr + k) % 4]) g = (m_ptr + k) % 4;
          m_owner = g;
          m_ptr   = (g + 1) % 4;
          m_phase = 1;
        end
      end else if (m_phase == 1) begin
        if (req_i[m_owner]) begin
          m_q     = wdata_i[m_owner*W +: W];
          m_done  = 1'b1;
          m_phase = 2;
          m_wait  = 0;
        end else begin
          m_phase = 0;
        end
      end else begin
        if (!req_i[m_owner]) begin
          m_phase = 0;
        end else begin
`ifdef ARB_TIMEOUT_EN
          if (m_wait == 7) begin
            m_phase = 0;
            m_to    = 1'b1;
          end else begin
            m_wait++;
          end
`endif
        end
      end
    end
  endtask

  task automatic cycle();
    logic [3:0] exp_gnt;
    @(posedge clk);
    model_step();
    #1;
    exp_gnt = (m_phase != 0) ? (4'b0001 << m_owner) : 4'b0000;
    chk("model_gnt", {28'd0, gnt}, {28'd0, exp_gnt});
    chk("model_q", {24'd0, q}, {24'd0, m_q});
    chk("model_done", {31'd0, done}, {31'd0, m_done});
    chk("model_busy", {31'd0, busy}, {31'd0, (m_phase != 0)});
    chk("model_timeout", {31'd0, timeout}, {31'd0, m_to});
  endtask

  initial begin
    logic [W-1:0] slices [4];
    int to_cnt;
    logic g10;
    clk = 1'b0;
    checks = 0;
    failures = 0;
    m_phase = 0; m_owner = 0; m_ptr = 0; m_wait = 0;
    m_q = '0; m_done = 1'b0; m_to = 1'b0;

    // reset with all requests asserted
    slices[0] = 8'h11; slices[1] = 8'h22; slices[2] = 8'h33; slices[3] = 8'h44;
    r_i = 1'b0;
    req_i = 4'b1111;
    wdata_i = {slices[3], slices[2], slices[1], slices[0]};
    cycle();
    cycle();
    chk("rst_gnt", {28'd0, gnt}, 32'd0);
    chk("rst_q", {24'd0, q}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);

    // round robin 0,1,2,3,0 with each owner dropping after its write
    r_i = 1'b1;
    for (int n = 0; n < 5; n++) begin
      cycle();
      chk("rr_gnt", {28'd0, gnt}, 32'd1 << (n % 4));
      cycle();
      chk("rr_q", {24'd0, q}, {24'd0, slices[n % 4]});
      chk("rr_done", {31'd0, done}, 32'd1);
      req_i[n % 4] = 1'b0;
      cycle();
      chk("rr_release", {28'd0, gnt}, 32'd0);
      req_i = 4'b1111;
    end
    req_i = 4'b0000;
    cycle();

    // single write from requester 2
    req_i = 4'b0100;
    wdata_i = {8'h00, 8'hA5, 8'h00, 8'h00};
    cycle();
    chk("sw_gnt", {28'd0, gnt}, 32'h4);
    chk("sw_done_early", {31'd0, done}, 32'd0);
    cycle();
    chk("sw_q", {24'd0, q}, 32'hA5);
    chk("sw_done", {31'd0, done}, 32'd1);
    req_i = 4'b0000;
    cycle();
    chk("sw_gnt_clr", {28'd0, gnt}, 32'd0);
    chk("sw_busy_clr", {31'd0, busy}, 32'd0);
    chk("sw_done_once", {31'd0, done}, 32'd0);

    // abort in GRANT
    req_i = 4'b0010;
    wdata_i = {4{8'h5A}};
    cycle();
    chk("ab_gnt", {28'd0, gnt}, 32'h2);
    req_i = 4'b0000;
    cycle();
    chk("ab_q", {24'd0, q}, 32'hA5);
    chk("ab_done", {31'd0, done}, 32'd0);
    chk("ab_busy", {31'd0, busy}, 32'd0);
    cycle();
    chk("ab_done_late", {31'd0, done}, 32'd0);

    // reset while requester 3 holds WAIT
    req_i = 4'b1000;
    wdata_i = {8'hC3, 8'h00, 8'h00, 8'h00};
    cycle();
    chk("rw_gnt", {28'd0, gnt}, 32'h8);
    cycle();
    chk("rw_q", {24'd0, q}, 32'hC3);
    r_i = 1'b0;
    cycle();
    chk("rw_gnt_rst", {28'd0, gnt}, 32'd0);
    chk("rw_q_rst", {24'd0, q}, 32'd0);
    r_i = 1'b1;
    req_i = 4'b1010;
    cycle();
    chk("rw_first_gnt", {28'd0, gnt}, 32'h2);
    req_i = 4'b0000;
    cycle();
    cycle();

    // requester 0 holds for 12 cycles
    req_i = 4'b0001;
    wdata_i = $urandom;
    to_cnt = 0;
    g10 = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      cycle();
      if (timeout) to_cnt++;
      if (i == 10) g10 = gnt[0];
    end
`ifdef ARB_TIMEOUT_EN
    chk("to_pulses", to_cnt, 32'd1);
    chk("to_gnt_released", {31'd0, g10}, 32'd0);
`else
    chk("to_pulses", to_cnt, 32'd0);
    chk("to_gnt_held", {31'd0, g10}, 32'd1);
`endif
    req_i = 4'b0000;
    cycle();
    cycle();

    // random traffic with occasional reset
    for (int i = 0; i < 400; i++) begin
      r_i = ($urandom_range(0, 39) == 0) ? 1'b0 : 1'b1;
      if ($urandom_range(0, 1) == 1) req_i = 4'($urandom_range(0, 15));
      wdata_i = $urandom;
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
